// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the streaming SDF FFT stages.
package fft_pkg;

  localparam int FRAC_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_BFLY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Round half up, then arithmetic shift.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int sh);
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] cplx_re(input logic [127:0] d, input int w);
    logic signed [63:0] t;
    t = $signed(64'(d >> w));
    return (t <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] cplx_im(input logic [127:0] d, input int w);
    logic signed [63:0] t;
    t = $signed(64'(d));
    return (t <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic [127:0] cplx_pack(input logic signed [63:0] re,
                                             input logic signed [63:0] im, input int w);
    logic [127:0] m;
    m = (128'd1 << w) - 128'd1;
    return ((128'($unsigned(re)) & m) << w) | (128'($unsigned(im)) & m);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Asynchronous-read twiddle table W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k < N/2,
// values truncated toward zero; the 16-point image is tabulated, others are generated.
module fft_twiddle_rom #(
  parameter int N       = 16,
  parameter int TW      = 18,
  parameter int FRAC    = 16,
  parameter     TW_FILE = "twiddle16.hex"
) (
  input  logic [$clog2(N/2)-1:0] addr,
  output logic signed [TW-1:0]   w_re,
  output logic signed [TW-1:0]   w_im
);

  localparam int HALF  = N / 2;
  localparam bit STD16 = (N == 16) && (FRAC == 16) && (TW_FILE == "twiddle16.hex");

  localparam int T16_RE [8] = '{65536, 60547, 46340, 25079, 0, -25079, -46340, -60547};
  localparam int T16_IM [8] = '{0, -25079, -46340, -60547, -65536, -60547, -46340, -25079};

  logic signed [TW-1:0] rom_re [HALF];
  logic signed [TW-1:0] rom_im [HALF];

  function automatic int tw_calc(input int k, input bit im);
    real x, term, c, s, v;
    x    = 2.0 * 3.141592653589793 * $itor(k) / $itor(N);
    c    = 0.0;
    s    = 0.0;
    term = 1.0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) c = c + ((((i / 2) % 2) != 0) ? -term : term);
      else            s = s + ((((i / 2) % 2) != 0) ? -term : term);
      term = term * x / $itor(i + 1);
    end
    v = (im ? -s : c) * (2.0 ** FRAC);
    // Small bias keeps exact values like 1.0 from truncating one LSB low.
    return (v >= 0.0) ? $rtoi(v + 1.0e-4) : -$rtoi(-v + 1.0e-4);
  endfunction

  for (genvar k = 0; k < HALF; k++) begin : g_rom
    if (STD16) begin : g_tab
      assign rom_re[k] = TW'(T16_RE[k % 8]);
      assign rom_im[k] = TW'(T16_IM[k % 8]);
    end else begin : g_calc
      localparam int VR = tw_calc(k, 1'b0);
      localparam int VI = tw_calc(k, 1'b1);
      assign rom_re[k] = TW'(VR);
      assign rom_im[k] = TW'(VI);
    end
  end

  assign w_re = rom_re[addr];
  assign w_im = rom_im[addr];

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback stage: N/2 sums stream out during the
// second half of the frame, then the N/2 twiddled differences drain from the buffer.
module fft_sdf_stage
  import fft_pkg::*;
#(
  parameter int N       = 16,
  parameter int DW      = 16,
  parameter int TW      = 18,
  parameter int FRAC    = FRAC_DEFAULT,
  parameter int SCALE   = 0,
  parameter     TW_FILE = "twiddle16.hex"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] out_data,
  output logic          out_last
);

  localparam int HALF = N / 2;
  localparam int KW   = $clog2(HALF);
  localparam int BW   = DW + 1;
  localparam int PW   = DW + TW + 2;

  state_t state, state_nx;
  logic [KW-1:0] cnt;
  logic          load, accept, last_k;

  logic signed [DW-1:0] in_re, in_im;
  logic signed [BW-1:0] buf_re [HALF];
  logic signed [BW-1:0] buf_im [HALF];
  logic signed [BW-1:0] a_re, a_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [DW-1:0] sum_re, sum_im, mul_re, mul_im;

  function automatic logic signed [DW-1:0] bfly_out(input logic signed [63:0] s);
    logic signed [63:0] t;
    t = (SCALE != 0) ? round_shr(s, 1) : s;
    t = sat_w(t, DW);
    return DW'(t);
  endfunction

  function automatic logic signed [DW-1:0] mul_out(input logic signed [63:0] p);
    logic signed [63:0] t;
    t = sat_w(round_shr(p, FRAC + SCALE), DW);
    return DW'(t);
  endfunction

  assign load   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign last_k = (cnt == KW'(HALF - 1));

  assign in_re = DW'(cplx_re(128'(in_data), DW));
  assign in_im = DW'(cplx_im(128'(in_data), DW));
  assign a_re  = buf_re[cnt];
  assign a_im  = buf_im[cnt];

  assign sum_re = bfly_out(64'(a_re) + 64'(in_re));
  assign sum_im = bfly_out(64'(a_im) + 64'(in_im));

  // In DRAIN the buffer holds the differences a-b, so the same read port feeds the multiplier.
  assign prod_re = PW'(a_re) * PW'(w_re) - PW'(a_im) * PW'(w_im);
  assign prod_im = PW'(a_re) * PW'(w_im) + PW'(a_im) * PW'(w_re);
  assign mul_re  = mul_out(64'(prod_re));
  assign mul_im  = mul_out(64'(prod_im));

  fft_twiddle_rom #(
    .N      (N),
    .TW     (TW),
    .FRAC   (FRAC),
    .TW_FILE(TW_FILE)
  ) u_rom (
    .addr(cnt),
    .w_re(w_re),
    .w_im(w_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_FILL:  if (accept && last_k) state_nx = ST_BFLY;
      ST_BFLY:  if (accept && last_k) state_nx = ST_DRAIN;
      ST_DRAIN: if (load && last_k)   state_nx = ST_FILL;
      default:  state_nx = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      ST_FILL: in_ready = 1'b1;
      ST_BFLY: in_ready = load;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state != ST_DRAIN && accept) || (state == ST_DRAIN && load)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delay line: first-half samples on FILL, replaced by differences on BFLY.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == ST_FILL) begin
        buf_re[cnt] <= BW'(in_re);
        buf_im[cnt] <= BW'(in_im);
      end else begin
        buf_re[cnt] <= a_re - BW'(in_re);
        buf_im[cnt] <= a_im - BW'(in_im);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (state == ST_BFLY && accept) begin
        out_valid <= 1'b1;
        out_data  <= (2*DW)'(cplx_pack(64'(sum_re), 64'(sum_im), DW));
      end else if (state == ST_DRAIN) begin
        out_valid <= 1'b1;
        out_last  <= last_k;
        out_data  <= (2*DW)'(cplx_pack(64'(mul_re), 64'(mul_im), DW));
      end
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Bench for fft_sdf_stage (N=16, DW=16): SCALE=0 and SCALE=1 instances share stimulus
// and are compared against a direct DIF-stage model.
module tb_fft_sdf_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic        in_ready_s1, out_valid_s1, out_last_s1;
  logic [31:0] out_data_s1;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] stim_q [$];
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic [31:0] got0 [$];
  logic [31:0] got1 [$];

  localparam int WR [8] = '{65536, 60547, 46340, 25079, 0, -25079, -46340, -60547};
  localparam int WI [8] = '{0, -25079, -46340, -60547, -65536, -60547, -46340, -25079};

  always #5 clk = ~clk;

  fft_sdf_stage #(.N(16), .DW(16), .TW(18), .FRAC(16), .SCALE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  fft_sdf_stage #(.N(16), .DW(16), .TW(18), .FRAC(16), .SCALE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1), .in_data(in_data),
    .out_valid(out_valid_s1), .out_ready(out_ready), .out_data(out_data_s1),
    .out_last(out_last_s1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd(input longint v, input int sh);
    longint half;
    half = longint'(1) << (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic [31:0] cp(input longint re, input longint im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {r, i};
  endfunction

  task automatic add_frame(input int xr [16], input int xi [16]);
    longint sr, si, dr, di, pr, pi;
    for (int i = 0; i < 16; i++) stim_q.push_back({16'(xr[i]), 16'(xi[i])});
    for (int k = 0; k < 8; k++) begin
      sr = longint'(xr[k]) + xr[k+8];
      si = longint'(xi[k]) + xi[k+8];
      exp0_q.push_back(cp(sat16(sr), sat16(si)));
      exp1_q.push_back(cp(sat16(rnd(sr, 1)), sat16(rnd(si, 1))));
    end
    for (int k = 0; k < 8; k++) begin
      dr = longint'(xr[k]) - xr[k+8];
      di = longint'(xi[k]) - xi[k+8];
      pr = dr * WR[k] - di * WI[k];
      pi = dr * WI[k] + di * WR[k];
      exp0_q.push_back(cp(sat16(rnd(pr, 16)), sat16(rnd(pi, 16))));
      exp1_q.push_back(cp(sat16(rnd(pr, 17)), sat16(rnd(pi, 17))));
    end
  endtask

  task automatic add_random_frame();
    int xr [16];
    int xi [16];
    for (int i = 0; i < 16; i++) begin
      xr[i] = int'($urandom_range(0, 65535)) - 32768;
      xi[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    add_frame(xr, xi);
  endtask

  // mode 0: full rate; 1: out_ready toggles 1,0,1,0 with random in_valid; 2: both random.
  task automatic run(input int mode, input int abort_at, output int rdy_low);
    int  cyc = 0, acc = 0, outn = 0;
    int  t_last = -100, t_first = -100;
    bit  done = 0;
    rdy_low = 0;
    got0.delete();
    got1.delete();
    while (!done) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = (stim_q.size() > 0) && (mode == 0 || $urandom_range(0, 2) != 0);
      in_data  = (stim_q.size() > 0) ? stim_q[0] : 32'h0;
      #1;
      if (!in_ready) rdy_low++;
      if ((acc % 16) >= 8) begin
        chk("bfly_rdy", in_ready, !out_valid || out_ready);
        chk("bfly_rdy_s1", in_ready_s1, !out_valid_s1 || out_ready);
      end
      if (mode == 0 && cyc == t_first + 1) chk("first_lat", out_valid, 1);
      if (mode == 0 && cyc == t_last + 8) chk("rdy_drain", in_ready, 0);
      if (mode == 0 && cyc == t_last + 9) begin
        chk("last_lat", out_last, 1);
        chk("rdy_back", in_ready, 1);
      end
      if (out_valid && out_ready) begin
        if (exp0_q.size() == 0) begin
          chk("extra_out", out_data, 32'hx);
        end else begin
          chk($sformatf("out%0d", outn % 16), out_data, exp0_q.pop_front());
          chk($sformatf("out%0d_s1", outn % 16), out_data_s1, exp1_q.pop_front());
          chk("last", out_last, (outn % 16) == 15);
          chk("vld_s1", out_valid_s1, 1);
          chk("last_s1", out_last_s1, (outn % 16) == 15);
          got0.push_back(out_data);
          got1.push_back(out_data_s1);
          outn++;
        end
      end
      if (in_valid && in_ready) begin
        void'(stim_q.pop_front());
        acc++;
        if (acc % 16 == 9) t_first = cyc;
        if (acc % 16 == 0) t_last = cyc;
      end
      cyc++;
      if (abort_at > 0 && acc == abort_at) done = 1;
      if (stim_q.size() == 0 && exp0_q.size() == 0) done = 1;
      if (cyc > 3000) begin
        chk("timeout", exp0_q.size(), 0);
        done = 1;
      end
    end
  endtask

  initial begin
    int xr [16];
    int xi [16];
    int low;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[1] = 32'h1000;
    add_frame(xr, xi);
    run(0, -1, low);
    chk("imp_o1", got0[1], 32'h10000000);
    chk("imp_o9", got0[9], 32'h0EC8F9E1);
    chk("imp_rdy_low", low, 8);

    xr[1] = 0; xr[4] = 32'h0200; xi[4] = 32'h0100;
    add_frame(xr, xi);
    run(0, -1, low);
    chk("imag_o4", got0[4], 32'h02000100);
    chk("imag_o12", got0[12], 32'h0100FE00);

    for (int i = 0; i < 16; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 32767; xi[0] = -32768; xr[8] = 32767; xi[8] = -32768;
    add_frame(xr, xi);
    run(0, -1, low);
    chk("sat_o0", got0[0], 32'h7FFF8000);
    chk("sat_o8", got0[8], 32'h00000000);
    chk("scl_o0", got1[0], 32'h7FFF8000);

    add_random_frame();
    add_random_frame();
    run(1, -1, low);
    add_random_frame();
    add_random_frame();
    run(2, -1, low);

    add_random_frame();
    add_random_frame();
    add_random_frame();
    run(0, -1, low);
    chk("b2b_rdy_low", low, 24);
    chk("b2b_outs", got0.size(), 48);

    add_random_frame();
    run(0, 10, low);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    stim_q.delete(); exp0_q.delete(); exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", in_ready, 1);
    add_random_frame();
    run(0, -1, low);
    chk("post_rst_outs", got0.size(), 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
